// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the data memory (slave):
// a valid/ready request channel and a valid-only response channel.
interface mem_stage_lsu_if #(
   parameter int XLEN = 64
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_we;
   logic [XLEN-1:0]   mem_req_addr;
   logic [XLEN-1:0]   mem_req_wdata;
   logic [XLEN/8-1:0] mem_req_wstrb;
   logic              mem_resp_valid;
   logic [XLEN-1:0]   mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one memory request per access, pipeline stall until done,
// byte-lane placement for stores and extract/extend for loads. Optional LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
   parameter  int XLEN = 64,
   localparam int OFFW = $clog2(XLEN/8)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] addr_in,
   input  logic [XLEN-1:0] wdata_in,
   mem_stage_lsu_if.master mem,
   output logic            stall_out,
   output logic            load_valid_out,
   output logic [XLEN-1:0] load_data_out,
   output logic            misalign_out
);

   localparam int         NB     = XLEN/8;
   localparam logic [1:0] MAX_SZ = 2'(OFFW);
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t state_q, state_d;

   logic            access, we_in, mis_in;
   logic [1:0]      sz_in, sz_q;
   logic [OFFW-1:0] align_mask, off_in, off_q;
   logic            sext_q, mis_q;
   logic [6:0]      ext_sh;
   logic [XLEN-1:0] rsh, rsh_l, ext;

   // A simultaneous read and write is treated as a load.
   assign access     = mem_read_in | mem_write_in;
   assign we_in      = mem_write_in & ~mem_read_in;
   assign sz_in      = (funct3_in[1:0] > MAX_SZ) ? MAX_SZ : funct3_in[1:0];
   assign align_mask = OFFW'((1 << sz_in) - 1);
   assign mis_in     = |(addr_in[OFFW-1:0] & align_mask);
   // Without the trap, sub-size offset bits are dropped so the access snaps to its natural boundary.
   assign off_in     = TRAP_EN ? addr_in[OFFW-1:0] : (addr_in[OFFW-1:0] & ~align_mask);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Payload is captured once in IDLE and held untouched until the next access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem.mem_req_we    <= 1'b0;
         mem.mem_req_addr  <= '0;
         mem.mem_req_wdata <= '0;
         mem.mem_req_wstrb <= '0;
         sz_q              <= '0;
         off_q             <= '0;
         sext_q            <= 1'b0;
         mis_q             <= 1'b0;
      end else if (state_q == IDLE && access) begin
         mem.mem_req_we    <= we_in;
         mem.mem_req_addr  <= {addr_in[XLEN-1:OFFW], {OFFW{1'b0}}};
         mem.mem_req_wdata <= wdata_in << {off_in, 3'b000};
         mem.mem_req_wstrb <= we_in ? (NB'((1 << (1 << sz_in)) - 1) << off_in) : '0;
         sz_q              <= sz_in;
         off_q             <= off_in;
         sext_q            <= ~funct3_in[2];
         mis_q             <= TRAP_EN & mis_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                      load_data_out <= '0;
      else if (state_q == RESP && mem.mem_resp_valid)  load_data_out <= ext;
   end

   // Left-justify the selected field, then shift back arithmetically or logically to extend it.
   always_comb begin
      rsh    = mem.mem_resp_rdata >> {off_q, 3'b000};
      ext_sh = 7'(XLEN - (8 << sz_q));
      rsh_l  = rsh << ext_sh;
      ext    = sext_q ? $unsigned($signed(rsh_l) >>> ext_sh) : (rsh_l >> ext_sh);
   end

   // NOTE: next-state defaults to the current state first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access) state_d = (TRAP_EN && mis_in) ? DONE : REQ;
         REQ:     if (mem.mem_req_ready) state_d = mem.mem_req_we ? DONE : RESP;
         RESP:    if (mem.mem_resp_valid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem.mem_req_valid = (state_q == REQ);
   assign stall_out         = (state_q == IDLE && access) || (state_q == REQ) || (state_q == RESP);
   assign load_valid_out    = (state_q == DONE) && !mem.mem_req_we && !mis_q;
   assign misalign_out      = (state_q == DONE) && mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset/misalign sequences and
// randomized accesses against a byte-level reference model.
module tb_mem_stage_lsu;
   localparam int XLEN = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
   logic [2:0]  funct3_in = 3'd0;
   logic [63:0] addr_in = '0, wdata_in = '0;
   logic        stall_out, load_valid_out, misalign_out;
   logic [63:0] load_data_out;

   mem_stage_lsu_if #(.XLEN(XLEN)) mem ();

   mem_stage_lsu #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
      .mem(mem),
      .stall_out(stall_out), .load_valid_out(load_valid_out),
      .load_data_out(load_data_out), .misalign_out(misalign_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          req;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        we;
      int          stall;
      int          lv;
      logic [63:0] data;
      int          mis;
   } exp_t;

   typedef struct {
      bit          rd, wr;
      logic [2:0]  f3;
      logic [63:0] a, wd, rdv;
      int          rdly, sdly;
      exp_t        e;
   } vec_t;

   int n_checks = 0, n_errors = 0;
   logic [63:0] last_load = '0;
   vec_t vecs[$];

   int          r_req, r_stall, r_lv, r_mis;
   bit          r_to, r_stable;
   logic [63:0] r_addr, r_wdata, r_lvdata, r_post;
   logic [7:0]  r_wstrb;
   logic        r_we, r_post_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(bit rd, bit wr, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                                logic [63:0] rdv, int rdly, int sdly, int ereq, logic [63:0] eaddr,
                                logic [63:0] ewdata, logic [7:0] ewstrb, logic ewe, int estall,
                                int elv, logic [63:0] edata);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.rdv = rdv;
      v.rdly = rdly; v.sdly = sdly;
      v.e = '{req: ereq, addr: eaddr, wdata: ewdata, wstrb: ewstrb, we: ewe, stall: estall,
              lv: elv, data: edata, mis: 0};
      return v;
   endfunction

   // Reference model: byte-by-byte gathering, cycle counts from the handshake delays.
   function automatic exp_t model(bit rd, bit wr, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                                  logic [63:0] rdv, int rdly, int sdly, logic [63:0] prev);
      exp_t        e;
      int          nb, off;
      bit          ld, trap;
      logic [63:0] a_eff, v;
      ld   = rd;
      nb   = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (a % 64'(nb)) != 0;
`else
      trap = 1'b0;
`endif
      a_eff   = trap ? a : a - (a % 64'(nb));
      off     = int'(a_eff % 64'd8);
      e.addr  = a - (a % 64'd8);
      e.we    = !ld;
      e.wstrb = ld ? 8'h00 : 8'(((1 << nb) - 1) << off);
      e.wdata = wd << (8 * off);
      v = '0;
      if (!trap) begin
         for (int i = 0; i < nb; i++) v[8*i +: 8] = rdv[8*(off+i) +: 8];
         if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      end
      if (trap) begin
         e.req = 0; e.stall = 1; e.lv = 0; e.mis = 1; e.data = prev;
      end else begin
         e.req   = rdly + 1;
         e.stall = 1 + (rdly + 1) + (ld ? sdly + 1 : 0);
         e.lv    = ld ? 1 : 0;
         e.mis   = 0;
         e.data  = ld ? v : prev;
      end
      return e;
   endfunction

   // Drives one access from posedge+1, plays the memory, and records what the DUT did.
   task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input logic [63:0] rdv, input int rdly,
                             input int sdly, input bit noise);
      bit in_resp, done, hs, rs;
      int rwait;
      r_req = 0; r_stall = 0; r_lv = 0; r_mis = 0; r_to = 1'b0; r_stable = 1'b1;
      r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0; r_lvdata = '0;
      mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = a; wdata_in = wd;
      in_resp = 1'b0; done = 1'b0; rwait = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (mem.mem_req_valid) begin
            if (r_req == 0) begin
               r_addr = mem.mem_req_addr; r_wdata = mem.mem_req_wdata;
               r_wstrb = mem.mem_req_wstrb; r_we = mem.mem_req_we;
            end else if (r_addr !== mem.mem_req_addr || r_wdata !== mem.mem_req_wdata ||
                         r_wstrb !== mem.mem_req_wstrb || r_we !== mem.mem_req_we) begin
               r_stable = 1'b0;
            end
            r_req++;
         end
         if (stall_out) r_stall++;
         else           done = 1'b1;
         if (load_valid_out) begin r_lv++; r_lvdata = load_data_out; end
         if (misalign_out) r_mis++;
         mem.mem_req_ready = mem.mem_req_valid && (r_req > rdly);
         if (in_resp) begin
            mem.mem_resp_valid = (rwait >= sdly);
            mem.mem_resp_rdata = mem.mem_resp_valid ? rdv : {$urandom, $urandom};
            rwait++;
         end else begin
            mem.mem_resp_valid = noise && ($urandom_range(0, 1) == 1);
            mem.mem_resp_rdata = {$urandom, $urandom};
         end
         hs = mem.mem_req_valid && mem.mem_req_ready && !mem.mem_req_we;
         rs = in_resp && mem.mem_resp_valid;
         @(posedge clk); #1;
         if (rs) in_resp = 1'b0;
         if (hs) begin in_resp = 1'b1; rwait = 0; end
      end
      r_to = !done;
      mem_read_in = 1'b0; mem_write_in = 1'b0;
      mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0;
      @(negedge clk);
      r_post = load_data_out; r_post_stall = stall_out;
      @(posedge clk); #1;
   endtask

   task automatic verify(input string tag, input exp_t e);
      check({tag, " timeout"}, 64'(r_to), 64'd0);
      check({tag, " stall_cycles"}, 64'(r_stall), 64'(e.stall));
      check({tag, " req_cycles"}, 64'(r_req), 64'(e.req));
      if (e.req > 0) begin
         check({tag, " req_addr"}, r_addr, e.addr);
         check({tag, " req_we"}, 64'(r_we), 64'(e.we));
         check({tag, " req_wstrb"}, 64'(r_wstrb), 64'(e.wstrb));
         check({tag, " payload_stable"}, 64'(r_stable), 64'd1);
         if (e.we) check({tag, " req_wdata"}, r_wdata, e.wdata);
      end
      check({tag, " load_valid_cycles"}, 64'(r_lv), 64'(e.lv));
      if (e.lv > 0) check({tag, " load_data"}, r_lvdata, e.data);
      check({tag, " misalign_cycles"}, 64'(r_mis), 64'(e.mis));
      check({tag, " load_data_hold"}, r_post, e.data);
      check({tag, " idle_stall"}, 64'(r_post_stall), 64'd0);
   endtask

   initial begin
      exp_t e;
      bit rd, wr;
      int sel, rdly, sdly, gap;
      logic [2:0]  f3;
      logic [63:0] a, wd, rdv;

      mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0; mem.mem_resp_rdata = '0;

      //         rd wr f3    addr        wdata                  rdata                  rd sd req eaddr       ewdata                 wstrb  we st lv edata
      vecs.push_back(mkv(1, 0, 3'd0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 1, 64'h1000, 64'h0, 8'h00, 0, 3, 1, 64'hFFFF_FFFF_FFFF_FF80));
      vecs.push_back(mkv(1, 0, 3'd4, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 1, 64'h1000, 64'h0, 8'h00, 0, 3, 1, 64'h80));
      vecs.push_back(mkv(0, 1, 3'd2, 64'h2004, 64'h1234_5678, 64'h0, 0, 0, 1, 64'h2000, 64'h1234_5678_0000_0000, 8'hF0, 1, 2, 0, 64'h0));
      vecs.push_back(mkv(1, 0, 3'd2, 64'h1000, 64'h0, 64'h1122_3344_5566_7788, 3, 0, 4, 64'h1000, 64'h0, 8'h00, 0, 6, 1, 64'h5566_7788));
      vecs.push_back(mkv(1, 1, 3'd3, 64'h3000, 64'hDEAD, 64'hCAFE_F00D_1234_5678, 0, 0, 1, 64'h3000, 64'h0, 8'h00, 0, 3, 1, 64'hCAFE_F00D_1234_5678));
      vecs.push_back(mkv(1, 0, 3'd1, 64'h1006, 64'h0, 64'hABCD_0000_0000_0000, 0, 2, 1, 64'h1000, 64'h0, 8'h00, 0, 5, 1, 64'hFFFF_FFFF_FFFF_ABCD));
      vecs.push_back(mkv(0, 1, 3'd0, 64'h4007, 64'hA5, 64'h0, 0, 0, 1, 64'h4000, 64'hA500_0000_0000_0000, 8'h80, 1, 2, 0, 64'h0));
      vecs.push_back(mkv(0, 1, 3'd3, 64'h5000, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0, 2, 64'h5000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 3, 0, 64'h0));
      vecs.push_back(mkv(1, 0, 3'd5, 64'h1002, 64'h0, 64'h0000_0000_F00D_0000, 0, 0, 1, 64'h1000, 64'h0, 8'h00, 0, 3, 1, 64'hF00D));
      vecs.push_back(mkv(1, 0, 3'd6, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 1, 1, 2, 64'h1000, 64'h0, 8'h00, 0, 5, 1, 64'h8765_4321));
      vecs.push_back(mkv(0, 1, 3'd1, 64'h6002, 64'hBEEF, 64'h0, 0, 0, 1, 64'h6000, 64'hBEEF_0000, 8'h0C, 1, 2, 0, 64'h0));

      // Reset state while reset is held.
      repeat (2) @(negedge clk);
      check("rst req_valid", 64'(mem.mem_req_valid), 64'd0);
      check("rst req_we", 64'(mem.mem_req_we), 64'd0);
      check("rst req_addr", mem.mem_req_addr, 64'd0);
      check("rst req_wdata", mem.mem_req_wdata, 64'd0);
      check("rst req_wstrb", 64'(mem.mem_req_wstrb), 64'd0);
      check("rst stall", 64'(stall_out), 64'd0);
      check("rst load_valid", 64'(load_valid_out), 64'd0);
      check("rst load_data", load_data_out, 64'd0);
      check("rst misalign", 64'(misalign_out), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         e = vecs[i].e;
         if (e.lv == 0) e.data = last_load;
         run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rdv,
                    vecs[i].rdly, vecs[i].sdly, 1'b0);
         verify($sformatf("vec%0d", i), e);
         if (e.lv > 0) last_load = e.data;
      end

      // Misaligned LW at 0x1002: trapped without a request, or snapped down to 0x1000.
      e = model(1'b1, 1'b0, 3'd2, 64'h1002, 64'h0, 64'h1111_2222_3333_4444, 0, 0, last_load);
      run_access(1'b1, 1'b0, 3'd2, 64'h1002, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis trap no_request", 64'(r_req), 64'd0);
      check("mis trap flag", 64'(r_mis), 64'd1);
`else
      check("mis snap addr", r_addr, 64'h1000);
      check("mis snap data", r_lvdata, 64'h3333_4444);
`endif
      verify("mis", e);
      if (e.lv > 0) last_load = e.data;

      // Reset during RESP, then a stale response after release.
      mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'd3; addr_in = 64'h7000;
      mem.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      check("rstresp valid_in_req", 64'(mem.mem_req_valid), 64'd1);
      @(posedge clk); #1;
      check("rstresp stall_in_resp", 64'(stall_out), 64'd1);
      check("rstresp valid_in_resp", 64'(mem.mem_req_valid), 64'd0);
      mem.mem_req_ready = 1'b0;
      reset = 1'b0; mem_read_in = 1'b0;
      #1;
      check("rstresp stall_after_rst", 64'(stall_out), 64'd0);
      check("rstresp addr_after_rst", mem.mem_req_addr, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rstresp load_valid c%0d", i), 64'(load_valid_out), 64'd0);
         check($sformatf("rstresp stall c%0d", i), 64'(stall_out), 64'd0);
         @(posedge clk); #1;
         mem.mem_resp_valid = 1'b0;
      end
      check("rstresp load_data", load_data_out, 64'd0);
      last_load = '0;

      // Randomized accesses with stray response strobes outside RESP.
      for (int n = 0; n < 150; n++) begin
         sel  = int'($urandom_range(0, 2));
         rd   = (sel != 1);
         wr   = (sel != 0);
         f3   = 3'($urandom_range(0, 7));
         a    = {$urandom, $urandom};
         wd   = {$urandom, $urandom};
         rdv  = {$urandom, $urandom};
         rdly = int'($urandom_range(0, 3));
         sdly = int'($urandom_range(0, 3));
         e = model(rd, wr, f3, a, wd, rdv, rdly, sdly, last_load);
         run_access(rd, wr, f3, a, wd, rdv, rdly, sdly, 1'b1);
         verify($sformatf("rnd%0d", n), e);
         if (e.lv > 0) last_load = e.data;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check($sformatf("rnd%0d gap_stall", n), 64'(stall_out), 64'd0);
            @(posedge clk); #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
